// File: rtl/rsflag_sema_arbiter.sv
// Round-robin semaphore arbiter: one shared resource, NUM_REQ requesters, one
// RS-style ownership flag per requester with optional forced revoke after TIMEOUT cycles.
module rsflag_sema_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] rel,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy,
   output logic [ID_W-1:0]    gnt_id,
   output logic               timeout_err,
   output logic [ID_W-1:0]    timeout_id
);

   localparam bit               TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t             state, state_d;
   logic [ID_W-1:0]    ptr, ptr_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic               busy_d;
   logic [ID_W-1:0]    gnt_id_d;
   logic               err_d;
   logic [ID_W-1:0]    tid_d;

   logic [NUM_REQ-1:0] rot_c;
   logic               found_c;
   logic [ID_W-1:0]    winner_c;
   logic [ID_W-1:0]    ptr_wrap_c;
   logic [NUM_REQ-1:0] onehot_c;
   logic [NUM_REQ-1:0] own_set_c;
   logic [NUM_REQ-1:0] own_clr_c;
   logic               owner_rel_c;
   int unsigned        w_idx;
   int unsigned        w_next;

   // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
   always_comb begin
      rot_c      = NUM_REQ'({req, req} >> ptr);
      found_c    = 1'b0;
      w_idx      = 0;
      w_next     = 0;
      winner_c   = '0;
      ptr_wrap_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found_c && rot_c[i]) begin
            found_c = 1'b1;
            w_idx   = 32'(ptr) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         end
      end
      w_next = w_idx + 1;
      if (w_next == NUM_REQ) w_next = 0;
      winner_c   = ID_W'(w_idx);
      ptr_wrap_c = ID_W'(w_next);
      onehot_c   = NUM_REQ'(1) << winner_c;
   end

   // Owner identity comes from the one-hot grant, so no index into rel is needed.
   assign owner_rel_c = |(rel & gnt);

   // Next-state and ownership set/clear; set and clear never fire in the same state.
   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      cnt_d     = cnt;
      gnt_id_d  = gnt_id;
      err_d     = timeout_err;
      tid_d     = timeout_id;
      own_set_c = '0;
      own_clr_c = '0;
      case (state)
         IDLE: begin
            if (found_c) begin
               own_set_c = onehot_c;
               gnt_id_d  = winner_c;
               cnt_d     = '0;
               ptr_d     = ptr_wrap_c;
               state_d   = GRANT;
            end
         end
         GRANT: begin
            cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            if (owner_rel_c) begin
               own_clr_c = gnt;
               gnt_id_d  = '0;
               state_d   = GAP;
            end else if (TO_EN && (cnt == TO_LAST)) begin
               own_clr_c = gnt;
               gnt_id_d  = '0;
               err_d     = 1'b1;
               tid_d     = gnt_id;
               state_d   = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            own_clr_c = gnt;
            gnt_id_d  = '0;
            state_d   = IDLE;
         end
      endcase
      gnt_d  = (gnt & ~own_clr_c) | own_set_c;
      busy_d = |gnt_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         gnt         <= '0;
         busy        <= 1'b0;
         gnt_id      <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= '0;
      end else if (init) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         gnt         <= '0;
         busy        <= 1'b0;
         gnt_id      <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= '0;
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         cnt         <= cnt_d;
         gnt         <= gnt_d;
         busy        <= busy_d;
         gnt_id      <= gnt_id_d;
         timeout_err <= err_d;
         timeout_id  <= tid_d;
      end
   end

`ifndef SYNTHESIS
   // Grant must never name two owners at once.
   always @(posedge clk) begin
      if (reset && !$onehot0(gnt)) begin
         $error("rsflag_sema_arbiter: gnt not onehot0: %b", gnt);
         $finish;
      end
   end
`endif

endmodule
